// File: rtl/parity_frame_receiver.sv
// parity_frame_receiver: deserializes start/data/parity/stop frames, checks parity and stop bit, counts bad frames
module parity_frame_receiver #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rx,
    input  logic              odd_mode,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [CNT_W-1:0]  err_count
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, next;
    logic [BW-1:0] bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic odd_l, perr_r, done, bad;
    always_comb begin
        next = !bit_en ? state :
               state == IDLE   ? (rx ? IDLE : DATA) :
               state == DATA   ? (bit_cnt == LAST ? PARITY : DATA) :
               state == PARITY ? STOP : IDLE;
    end
    assign busy = state != IDLE;
    assign done = bit_en && state == STOP;
    assign bad  = perr_r | ~rx;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            odd_l      <= 1'b0;
            perr_r     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            data_valid <= done;
            if (bit_en && state == IDLE && !rx) begin
                odd_l   <= odd_mode;
                bit_cnt <= '0;
            end
            if (bit_en && state == DATA) begin
                shreg   <= DATA_W'({shreg, rx});
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (bit_en && state == PARITY) perr_r <= ((^shreg) ^ rx) != odd_l;
            if (done) begin
                data_out   <= shreg;
                parity_err <= perr_r;
                frame_err  <= ~rx;
            end
            // clear wins over a coincident increment
            if (err_clr) err_count <= '0;
            else if (done && bad && !(&err_count)) err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_parity_frame_receiver.sv
// tb_parity_frame_receiver: directed and random frames checked against a frame-level reference model
module tb_parity_frame_receiver;
    logic clk = 0, rst = 1, bit_en = 0, rx = 1, odd_mode = 0, err_clr = 0;
    logic [3:0] data_out;
    logic data_valid, parity_err, frame_err, busy;
    logic [1:0] err_count;
    int checks = 0, errors = 0;
    int m_cnt = 0;
    parity_frame_receiver #(.DATA_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .rx(rx), .odd_mode(odd_mode),
        .err_clr(err_clr), .data_out(data_out), .data_valid(data_valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy), .err_count(err_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick(input logic en, input logic r);
        bit_en = en;
        rx = r;
        @(posedge clk);
        #1;
    endtask
    task automatic gaps(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'($urandom));
            chk("gap_busy", busy, 1);
            chk("gap_dv", data_valid, 0);
        end
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'($urandom), 1'b1);
            chk("idle_busy", busy, 0);
        end
    endtask
    task automatic send_frame(input logic [3:0] d, input logic p, input logic stop,
                              input logic odd, input logic clr, input int gap);
        logic perr, ferr;
        odd_mode = odd;
        tick(1'b1, 1'b0);
        chk("start_busy", busy, 1);
        chk("start_dv", data_valid, 0);
        odd_mode = 1'($urandom);
        gaps(gap);
        for (int i = 3; i >= 0; i--) begin
            tick(1'b1, d[i]);
            gaps(gap);
        end
        tick(1'b1, p);
        chk("par_dv", data_valid, 0);
        gaps(gap);
        err_clr = clr;
        tick(1'b1, stop);
        err_clr = 0;
        perr = ((^d) ^ p) != odd;
        ferr = !stop;
        if (clr) m_cnt = 0;
        else if ((perr || ferr) && m_cnt < 3) m_cnt++;
        chk("dv", data_valid, 1);
        chk("data", data_out, d);
        chk("perr", parity_err, perr);
        chk("ferr", frame_err, ferr);
        chk("errcnt", err_count, m_cnt);
        chk("done_busy", busy, 0);
    endtask
    initial begin
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("rst_data", data_out, 0);
        chk("rst_dv", data_valid, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", err_count, 0);
        rst = 0;
        idle(2);
        send_frame(4'hB, 1, 1, 0, 0, 0);
        tick(1'b0, 1'b1);
        chk("pulse_end", data_valid, 0);
        chk("hold_data", data_out, 4'hB);
        send_frame(4'hB, 0, 1, 1, 0, 0);
        send_frame(4'hB, 1, 1, 1, 0, 0);
        send_frame(4'hF, 1, 1, 0, 0, 0);
        send_frame(4'hB, 1, 0, 0, 0, 0);
        tick(1'b1, 1'b1);
        chk("nostart_busy", busy, 0);
        send_frame(4'h6, 0, 1, 0, 0, 3);
        odd_mode = 0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        rst = 1;
        tick(1'b1, 1'b1);
        rst = 0;
        m_cnt = 0;
        chk("mrst_busy", busy, 0);
        chk("mrst_dv", data_valid, 0);
        chk("mrst_data", data_out, 0);
        chk("mrst_perr", parity_err, 0);
        chk("mrst_ferr", frame_err, 0);
        chk("mrst_cnt", err_count, 0);
        tick(1'b1, 1'b1);
        chk("mrst_dv2", data_valid, 0);
        send_frame(4'h1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) send_frame(4'h3, 1, 1, 0, 0, 0);
        send_frame(4'h3, 1, 1, 0, 1, 0);
        for (int i = 0; i < 150; i++) begin
            send_frame(4'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                       1'($urandom), ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
            if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
